seven_seg_driver: RTL and testbench

Parametrised multi-digit seven-segment display driver. It latches a binary value on a load strobe and converts it to decimal with a sequential double-dabble engine, or splits it into hex nibbles. It then time-multiplexes the digits onto shared segment lines. This block supersedes the fixed 8-bit, single-mode seven_seg top and is instantiated directly by board tops.

---
 rtl/seven_seg_driver.sv | 178 +++++++++++++++++
 tb/tb_seven_seg_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_driver.sv
// Multi-digit seven-segment driver: latches a binary value on load, converts it to
// decimal with a sequential double-dabble engine (or splits it into hex nibbles),
// and time-multiplexes the digits onto shared segment lines with a free-running scanner.
// Ports: clk, rst (sync, active-high), value/load/hex_mode in; busy, overflow, seg[6:0]
// ({g..a}), dig[DIGITS-1:0] (one-hot, dig[0] = least significant digit) out.
// Optional: define SEVEN_SEG_LZB_EN to blank leading zero digits.

module seven_seg_driver #(
  parameter int DIGITS     = 3,
  parameter int WIDTH      = 8,
  parameter int DIG_CYCLES = 12000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  input  logic              hex_mode,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig
);

  localparam int NW = 4 * DIGITS;          // displayed nibbles
  localparam int BW = NW + 4;              // BCD register with one spare digit for overflow
  localparam int PW = WIDTH + NW;          // value zero-padded past the displayed nibbles
  localparam int IW = $clog2(WIDTH + 1);
  localparam int CW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
  localparam int XW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef SEVEN_SEG_LZB_EN
  // Reset shows value 0: only digit 0 is lit.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
`else
  localparam logic [DIGITS-1:0] BLANK_RST = '0;
`endif

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t            state;
  logic [WIDTH-1:0]  bin;
  logic              hex_r;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     bcd_adj;
  logic              sticky;
  logic [IW-1:0]     iter;
  logic [PW-1:0]     bin_pad;
  logic [NW-1:0]     cand_nib;
  logic [DIGITS-1:0] cand_blank;
  logic              cand_ovf;
  logic [NW-1:0]     disp_nib;
  logic [DIGITS-1:0] disp_blank;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic [XW-1:0]     idx;
  logic [3:0]        cur_nib;
  logic [6:0]        seg_lit;
  logic [DIGITS-1:0] dig_lit;
`ifdef SEVEN_SEG_LZB_EN
  logic              lz_run;
`endif

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Candidate display contents, written atomically at COMMIT.
  // Decimal overflow: anything in the spare digit or anything shifted past it.
  always_comb begin
    bin_pad = PW'(bin);
    if (hex_r) begin
      cand_nib = bin_pad[NW-1:0];
      cand_ovf = |bin_pad[PW-1:NW];
    end else begin
      cand_nib = bcd[NW-1:0];
      cand_ovf = sticky | (|bcd[BW-1:NW]);
    end
    cand_blank = '0;
`ifdef SEVEN_SEG_LZB_EN
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run        = lz_run && (cand_nib[4*i +: 4] == 4'd0);
      cand_blank[i] = lz_run;
    end
    if (cand_ovf) cand_blank = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      bin        <= '0;
      hex_r      <= 1'b0;
      bcd        <= '0;
      sticky     <= 1'b0;
      iter       <= '0;
      disp_nib   <= '0;
      disp_blank <= BLANK_RST;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin    <= value;
            hex_r  <= hex_mode;
            bcd    <= '0;
            sticky <= 1'b0;
            iter   <= IW'(WIDTH);
            busy   <= 1'b1;
            state  <= hex_mode ? COMMIT : CONV;
          end
        end
        CONV: begin
          bcd    <= {bcd_adj[BW-2:0], bin[WIDTH-1]};
          bin    <= bin << 1;
          sticky <= sticky | bcd_adj[BW-1];
          iter   <= iter - 1'b1;
          if (iter == IW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          disp_nib   <= cand_nib;
          disp_blank <= cand_blank;
          overflow   <= cand_ovf;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running scanner. The dwell counter wraps DIG_CYCLES-1 .. 0 and the digit
  // advances on the cycle it lands on 0; reset leaves it at 0 so digit 0 still
  // gets a full DIG_CYCLES dwell after reset.
  assign cnt_next = (cnt == '0) ? CW'(DIG_CYCLES - 1) : cnt - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      if (cnt_next == '0) idx <= (idx == XW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    cur_nib = disp_nib[{idx, 2'b00} +: 4];
    if (rst)                  seg_lit = 7'h00;
    else if (overflow)        seg_lit = 7'h40;
    else if (disp_blank[idx]) seg_lit = 7'h00;
    else                      seg_lit = decode(cur_nib);
    dig_lit = rst ? '0 : (DIGITS'(1) << idx);
  end

  assign seg = (ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
  assign dig = (ACTIVE_LOW != 0) ? ~dig_lit : dig_lit;

endmodule

// File: tb/tb_seven_seg_driver.sv
module tb_seven_seg_driver;

  localparam int WIDTH = 8;
  localparam int DC    = 4;

`ifdef SEVEN_SEG_LZB_EN
  localparam logic [6:0] LZ0 = 7'h00;
`else
  localparam logic [6:0] LZ0 = 7'h3F;
`endif

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic       load;
  logic       hex_mode;
  logic       busy3, ovf3, busy2, ovf2;
  logic [6:0] seg3, seg2;
  logic [2:0] dig3;
  logic [1:0] dig2;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural reference state
  int scan_k;
  int busy_left;
  int pend_val;
  bit pend_hex;
  int disp_val;
  bit disp_hex;

  seven_seg_driver #(.DIGITS(3), .WIDTH(WIDTH), .DIG_CYCLES(DC), .ACTIVE_LOW(0)) dut3 (
    .clk(clk), .rst(rst), .value(value), .load(load), .hex_mode(hex_mode),
    .busy(busy3), .overflow(ovf3), .seg(seg3), .dig(dig3));

  seven_seg_driver #(.DIGITS(2), .WIDTH(WIDTH), .DIG_CYCLES(DC), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst(rst), .value(value), .load(load), .hex_mode(hex_mode),
    .busy(busy2), .overflow(ovf2), .seg(seg2), .dig(dig2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pow_b(input bit h, input int i);
    int r = 1;
    for (int k = 0; k < i; k++) r = r * (h ? 16 : 10);
    return r;
  endfunction

  function automatic bit exp_ovf(input int v, input bit h, input int n);
    return v >= pow_b(h, n);
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input bit h, input int n, input int i);
    int d;
    if (exp_ovf(v, h, n)) return 7'h40;
`ifdef SEVEN_SEG_LZB_EN
    if (i > 0 && v < pow_b(h, i)) return 7'h00;
`endif
    d = (v / pow_b(h, i)) % (h ? 16 : 10);
    return SEG_TBL[d];
  endfunction

  // Model: scan position from cycles since reset, load acceptance and commit timing.
  always @(posedge clk) begin
    if (rst) begin
      scan_k = 0; busy_left = 0; disp_val = 0; disp_hex = 1'b0;
    end else begin
      scan_k++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          disp_val = pend_val;
          disp_hex = pend_hex;
        end
      end else if (load) begin
        pend_val  = int'(value);
        pend_hex  = hex_mode;
        busy_left = hex_mode ? 1 : WIDTH + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int i3, i2;
      i3 = (scan_k / DC) % 3;
      i2 = (scan_k / DC) % 2;
      chk("busy3", 32'(busy3), 32'(busy_left > 0));
      chk("busy2", 32'(busy2), 32'(busy_left > 0));
      chk("ovf3", 32'(ovf3), 32'(exp_ovf(disp_val, disp_hex, 3)));
      chk("ovf2", 32'(ovf2), 32'(exp_ovf(disp_val, disp_hex, 2)));
      chk("dig3", 32'(dig3), rst ? 32'd0 : (32'd1 << i3));
      chk("dig2", 32'(dig2), rst ? 32'd0 : (32'd1 << i2));
      chk("seg3", 32'(seg3), rst ? 32'd0 : 32'(exp_seg(disp_val, disp_hex, 3, i3)));
      chk("seg2", 32'(seg2), rst ? 32'd0 : 32'(exp_seg(disp_val, disp_hex, 2, i2)));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive a one-cycle load, then count busy cycles (bounded).
  task automatic do_load(input int v, input bit h, output int nbusy);
    step();
    value = v[7:0]; hex_mode = h; load = 1'b1;
    step();
    load = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 60 && busy3; i++) begin
      nbusy++;
      step();
    end
    if (busy3) chk("busy_timeout", 32'(busy3), 32'd0);
  endtask

  // Literal per-digit expectations over one full scan round.
  task automatic check_lit(input string nm, input bit two,
                           input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
    logic [2:0] d;
    logic [6:0] s, e;
    for (int c = 0; c < 3 * DC; c++) begin
      @(negedge clk);
      d = two ? {1'b0, dig2} : dig3;
      s = two ? seg2 : seg3;
      chk({nm, "_onehot"}, 32'($onehot(d)), 32'd1);
      case (d)
        3'b001:  e = e0;
        3'b010:  e = e1;
        3'b100:  e = e2;
        default: e = 7'h7F;
      endcase
      chk(nm, 32'(s), 32'(e));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    rst = 1'b1; load = 1'b0; value = '0; hex_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dig", 32'(dig3), 32'd0);
    chk("rst_seg", 32'(seg3), 32'd0);
    chk("rst_busy", 32'(busy3), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("first_dig", 32'(dig3), 32'd1);
    check_lit("reset_disp", 1'b0, 7'h3F, LZ0, LZ0);

    do_load(255, 1'b0, nb);
    chk("dec_busy_len", 32'(nb), 32'd9);
    check_lit("dec255", 1'b0, 7'h6D, 7'h6D, 7'h5B);

    do_load(7, 1'b0, nb);
    check_lit("dec7", 1'b0, 7'h07, LZ0, LZ0);

    do_load(8'hAF, 1'b1, nb);
    chk("hex_busy_len", 32'(nb), 32'd1);
    check_lit("hexAF", 1'b0, 7'h71, 7'h77, LZ0);
    chk("hexAF_ovf2", 32'(ovf2), 32'd0);

    do_load(100, 1'b0, nb);
    chk("ovf2_100", 32'(ovf2), 32'd1);
    check_lit("ovf2_disp", 1'b1, 7'h40, 7'h40, 7'h00);
    do_load(99, 1'b0, nb);
    chk("ovf2_clear", 32'(ovf2), 32'd0);
    check_lit("dec99_d2", 1'b1, 7'h6F, 7'h6F, 7'h00);

    // Second load while busy is dropped.
    step(); value = 8'd123; hex_mode = 1'b0; load = 1'b1;
    step(); load = 1'b0;
    step(); value = 8'd45; load = 1'b1;
    step(); load = 1'b0;
    for (int i = 0; i < 60 && busy3; i++) step();
    chk("drop_busy", 32'(busy3), 32'd0);
    check_lit("drop123", 1'b0, 7'h4F, 7'h5B, 7'h06);

    // Reset mid-conversion aborts.
    step(); value = 8'd200; hex_mode = 1'b0; load = 1'b1;
    step(); load = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("abort_busy", 32'(busy3), 32'd0);
    rst = 1'b0;
    check_lit("abort_disp", 1'b0, 7'h3F, LZ0, LZ0);
    chk("abort_ovf2", 32'(ovf2), 32'd0);

    // Randomized traffic, checked every cycle by the model compare.
    for (int n = 0; n < 2500; n++) begin
      step();
      load     = ($urandom_range(0, 3) == 0);
      value    = 8'($urandom);
      hex_mode = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 199) == 0);
    end
    step();
    load = 1'b0; rst = 1'b0;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
